// File: rtl/read_check_pkg.sv
// -----------------------------------------------------------------------------
// read_check_pkg
// Shared definitions for the SDRAM read-check master:
//   state_t          - controller states (IDLE, READ, WAIT_DATA, DONE)
//   DEFAULT_PATTERN  - value every word is expected to hold
//   ERR_COUNT_MAX    - saturation value of the mismatch counter
//   sat_inc16()      - saturating 16-bit increment used for error counting
// -----------------------------------------------------------------------------
package read_check_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ      = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_PATTERN = 32'hDEADBEEF;
    localparam logic [15:0] ERR_COUNT_MAX   = 16'hFFFF;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == ERR_COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/read_check_master_if.sv
// -----------------------------------------------------------------------------
// read_check_master_if
// Avalon-MM read bus between the read-check master and the SDRAM slave.
//   address       master -> slave  word address
//   read_n        master -> slave  read strobe, active-low
//   byteenable    master -> slave  byte lanes (always all ones)
//   readdata      slave -> master  returned word
//   readdatavalid slave -> master  readdata qualifier
//   waitrequest   slave -> master  stall for the current command
// -----------------------------------------------------------------------------
interface read_check_master_if #(
    parameter int ADDRESSWIDTH    = 25,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4
);
    logic [ADDRESSWIDTH-1:0]    address;
    logic                       read_n;
    logic [BYTEENABLEWIDTH-1:0] byteenable;
    logic [DATAWIDTH-1:0]       readdata;
    logic                       readdatavalid;
    logic                       waitrequest;

    modport master (
        output address,
        output read_n,
        output byteenable,
        input  readdata,
        input  readdatavalid,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read_n,
        input  byteenable,
        output readdata,
        output readdatavalid,
        output waitrequest
    );
endinterface

// File: rtl/read_check_master_watchdog.sv
// -----------------------------------------------------------------------------
// rc_watchdog
// Per-word watchdog counter for the read-check master.
//   clk     in   clock
//   reset   in   synchronous active-high reset
//   load    in   clear the count (start of a new word)
//   enable  in   count this cycle
//   expire  out  asserted in the cycle the count reaches LIMIT-1 while enabled,
//                so the owner leaves its wait state exactly LIMIT cycles after
//                the count was cleared
// -----------------------------------------------------------------------------
module rc_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            count_q <= '0;
        end else if (enable && (count_q != CW'(LIMIT))) begin
            // Stop at LIMIT so a late owner reaction can never wrap the count.
            count_q <= count_q + CW'(1);
        end
    end

    assign expire = enable && (count_q >= CW'(LIMIT - 1));

endmodule

// File: rtl/read_check_master.sv
// -----------------------------------------------------------------------------
// read_check_master
// Reads word_count consecutive SDRAM words starting at base_address over an
// Avalon-MM master port and compares each to PATTERN, counting mismatches and
// remembering the address of the first one.
//
// Ports
//   clk                  in   clock, rising edge
//   reset                in   synchronous active-high reset
//   start                in   one-cycle run request (ignored while busy)
//   base_address         in   first word address of the run
//   word_count           in   number of words to read (0 -> immediate done)
//   av                   master modport of read_check_master_if (Avalon bus)
//   busy                 out  high in READ and WAIT_DATA
//   done                 out  high in DONE; status held until next start
//   error_count          out  saturating mismatch count
//   first_error_address  out  address of the first mismatching word
//   timeout              out  run ended by the per-word watchdog
//
// Build option
//   READ_CHECK_TIMEOUT_EN - compiles in the rc_watchdog per-word watchdog
//   (TIMEOUT_CYCLES cycles per word). Without it timeout is constant 0 and a
//   missing response stalls the run indefinitely.
// -----------------------------------------------------------------------------
module read_check_master
    import read_check_pkg::*;
#(
    parameter int                   ADDRESSWIDTH    = 25,
    parameter int                   DATAWIDTH       = 32,
    parameter int                   BYTEENABLEWIDTH = 4,
    parameter logic [DATAWIDTH-1:0] PATTERN         = DATAWIDTH'(DEFAULT_PATTERN),
    parameter int                   TIMEOUT_CYCLES  = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESSWIDTH-1:0] base_address,
    input  logic [15:0]             word_count,
    read_check_master_if.master     av,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             error_count,
    output logic [ADDRESSWIDTH-1:0] first_error_address,
    output logic                    timeout
);

    state_t                  state_q;
    logic [ADDRESSWIDTH-1:0] address_q;
    logic [15:0]             remaining_q;
    logic                    read_n_q;
    logic                    busy_q;
    logic                    done_q;
    logic [15:0]             error_count_q;
    logic [ADDRESSWIDTH-1:0] first_error_address_q;
    logic                    timeout_q;
    logic                    timeout_hit;

`ifdef READ_CHECK_TIMEOUT_EN
    logic wd_load;
    logic wd_enable;

    // The count restarts every time the FSM is about to enter READ, both at
    // run start and when moving on to the next word.
    assign wd_load = (((state_q == IDLE) || (state_q == DONE)) && start && (word_count != 16'd0))
                  || ((state_q == WAIT_DATA) && av.readdatavalid && (remaining_q != 16'd1));
    assign wd_enable = busy_q;

    rc_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .load   (wd_load),
        .enable (wd_enable),
        .expire (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q               <= IDLE;
            address_q             <= '0;
            remaining_q           <= '0;
            read_n_q              <= 1'b1;
            busy_q                <= 1'b0;
            done_q                <= 1'b0;
            error_count_q         <= '0;
            first_error_address_q <= '0;
            timeout_q             <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        address_q             <= base_address;
                        remaining_q           <= word_count;
                        error_count_q         <= '0;
                        first_error_address_q <= '0;
                        timeout_q             <= 1'b0;
                        if (word_count == 16'd0) begin
                            state_q  <= DONE;
                            read_n_q <= 1'b1;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            state_q  <= READ;
                            read_n_q <= 1'b0;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                        end
                    end
                end

                READ: begin
                    // An accepted command takes priority over a simultaneous
                    // expiry; the watchdog then fires in WAIT_DATA if needed.
                    if (!av.waitrequest) begin
                        state_q  <= WAIT_DATA;
                        read_n_q <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q   <= DONE;
                        read_n_q  <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end

                WAIT_DATA: begin
                    if (av.readdatavalid) begin
                        if (av.readdata != PATTERN) begin
                            error_count_q <= sat_inc16(error_count_q);
                            // A zero count means no mismatch yet in this run
                            // (the counter saturates, so it never wraps to 0).
                            if (error_count_q == 16'd0) begin
                                first_error_address_q <= address_q;
                            end
                        end
                        if (remaining_q == 16'd1) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= READ;
                            read_n_q    <= 1'b0;
                            address_q   <= address_q + ADDRESSWIDTH'(1);
                            remaining_q <= remaining_q - 16'd1;
                        end
                    end else if (timeout_hit) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    read_n_q <= 1'b1;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign av.address = address_q;
    assign av.read_n  = read_n_q;

    generate
        for (genvar gi = 0; gi < BYTEENABLEWIDTH; gi++) begin : g_byteenable
            assign av.byteenable[gi] = 1'b1;
        end
    endgenerate

    assign busy                = busy_q;
    assign done                = done_q;
    assign error_count         = error_count_q;
    assign first_error_address = first_error_address_q;
    assign timeout             = timeout_q;

endmodule

// File: doc/read_check_master.md
READ_CHECK_MASTER -- requirements
Module: read_check_master

Interface
REQ-001 SHALL have parameter ADDRESSWIDTH, default 25, word address width of the SDRAM Avalon port.
REQ-002 SHALL have parameter DATAWIDTH, default 32, read data width.
REQ-003 SHALL have parameter BYTEENABLEWIDTH, default 4, byteenable width.
REQ-004 SHALL have parameter PATTERN, default 32'hDEADBEEF, expected value of every word read.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit per word (used only under REQ-030).
REQ-006 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to begin a check run.
REQ-009 base_address  in  ADDRESSWIDTH  first word address of the run.
REQ-010 word_count  in  16  number of words to read.
REQ-011 address  out  ADDRESSWIDTH  Avalon master address.
REQ-012 read_n  out  1  Avalon read strobe, active-low.
REQ-013 byteenable  out  BYTEENABLEWIDTH  constant all-ones.
REQ-014 readdata  in  DATAWIDTH; readdatavalid  in  1; waitrequest  in  1  Avalon slave responses.
REQ-015 busy  out  1; done  out  1; error_count  out  16; first_error_address  out  ADDRESSWIDTH; timeout  out  1  run status.

Function
REQ-016 SHALL implement states IDLE, READ, WAIT_DATA, DONE; busy=1 exactly in READ and WAIT_DATA; done=1 exactly in DONE.
REQ-017 IDLE or DONE with start=1: latch base_address into address, word_count into remaining counter, clear error_count, first_error_address, timeout; go READ, or DONE if word_count=0.
REQ-018 READ: read_n=0, address held stable; waitrequest=0 -> WAIT_DATA next cycle; waitrequest=1 -> stay.
REQ-019 WAIT_DATA: read_n=1; on readdatavalid=1 compare readdata to PATTERN; remaining=1 -> DONE, else address+1 and READ.
REQ-020 Mismatch: error_count +1, saturating at 16'hFFFF; first mismatch of a run loads first_error_address with current address; later mismatches leave it unchanged.
REQ-021 Address increment SHALL wrap modulo 2^ADDRESSWIDTH.
REQ-022 readdatavalid outside WAIT_DATA, and start while busy=1, SHALL be ignored.
REQ-023 Zero-wait timing: start at cycle 0 -> first read at cycle 1, two cycles per word, done=1 at cycle 1+2N.
REQ-024 DONE SHALL hold all status outputs until next start.

Reset
REQ-025 reset=1 SHALL force state IDLE, address=0, read_n=1, busy=0, done=0, error_count=0, first_error_address=0, timeout=0 at the next clock edge.
REQ-026 Reset mid-run SHALL abandon the outstanding read; a late readdatavalid after reset SHALL have no effect.

Configuration
REQ-027 Macro READ_CHECK_TIMEOUT_EN SHALL compile in a per-word watchdog.
REQ-028 With macro: counter cleared on entering READ for each word, increments in READ/WAIT_DATA; reaching TIMEOUT_CYCLES -> timeout=1, read_n=1, go DONE.
REQ-029 Without macro: no watchdog logic; timeout tied 0; block waits indefinitely.
REQ-030 TIMEOUT_CYCLES SHALL be unused without the macro.

Structure
REQ-031 Shared package read_check_pkg SHALL hold state_t enum (IDLE, READ, WAIT_DATA, DONE) and default pattern constant 32'hDEADBEEF.
REQ-032 One sub-module rc_watchdog (load/enable/expire counter) SHALL be instantiated only under READ_CHECK_TIMEOUT_EN.

Verification
REQ-033 base 0x100, count 4, zero-wait slave returning DEADBEEF -> reads at 0x100..0x103, done at cycle 9, error_count 0.
REQ-034 Same run, word at 0x101 and 0x103 return 0 -> error_count 2, first_error_address 0x101.
REQ-035 waitrequest held 3 cycles per read -> read_n=0 and address stable throughout; each word read exactly once.
REQ-036 base 0x1FFFFFF, count 2 -> second read address 0x0000000; count 0 -> done at cycle 1, no reads.
REQ-037 reset in WAIT_DATA, readdatavalid with bad data next cycle -> all outputs at reset values, error_count 0.
REQ-038 Macro on, TIMEOUT_CYCLES 16, readdatavalid never -> timeout=1, done=1 16 cycles after read; macro off -> timeout 0, busy stays 1.
